// File: rtl/rover_location_filter_if.sv
// Port bundle between the location calculator, the smoothing filter and the
// rover path/display logic.
interface rover_location_filter_if #(
   parameter int DEPTH_LOG2 = 2
);
   logic                  location_valid;
   logic [11:0]           rover_location;
   logic [11:0]           filtered_location;
   logic                  filtered_valid;
   logic                  rejected;
   logic                  overrun;
   logic [DEPTH_LOG2:0]   sample_count;
   logic [2:0]            state;

   modport master (
      output location_valid,
      output rover_location,
      input  filtered_location,
      input  filtered_valid,
      input  rejected,
      input  overrun,
      input  sample_count,
      input  state
   );

   modport slave (
      input  location_valid,
      input  rover_location,
      output filtered_location,
      output filtered_valid,
      output rejected,
      output overrun,
      output sample_count,
      output state
   );
endinterface

// File: rtl/rover_location_filter.sv
// Outlier-rejecting running-mean filter for {angle_index, distance} results.
// Accepted distances for the current angle live in a DEPTH-entry ring buffer.
module rover_location_filter #(
   parameter int DEPTH_LOG2   = 2,
   parameter int MAX_JUMP     = 24,
   parameter int REJECT_LIMIT = 3
) (
   input  logic                     clock,
   input  logic                     reset,
   rover_location_filter_if.slave   bus
);

   localparam int DEPTH = 1 << DEPTH_LOG2;
   localparam int CW    = DEPTH_LOG2 + 1;
   localparam int SW    = 8 + DEPTH_LOG2;
   localparam int RW    = $clog2(REJECT_LIMIT + 1);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      CHECK  = 3'd1,
      ACCUM  = 3'd2,
      OUTPUT = 3'd3
   } state_e;

   state_e                state_q,    state_d;
   logic [11:0]           in_q,       in_d;
   logic [3:0]            angle_q,    angle_d;
   logic [7:0]            last_q,     last_d;
   logic [7:0]            buf_q [DEPTH];
   logic [7:0]            buf_d [DEPTH];
   logic [DEPTH_LOG2-1:0] wr_ptr_q,   wr_ptr_d;
   logic [CW-1:0]         count_q,    count_d;
   logic [RW-1:0]         rej_q,      rej_d;
   logic [DEPTH_LOG2-1:0] acc_idx_q,  acc_idx_d;
   logic [SW-1:0]         sum_q,      sum_d;
   logic [11:0]           out_q,      out_d;
   logic                  fvalid_q,   fvalid_d;
   logic                  rejected_q, rejected_d;
   logic                  overrun_q,  overrun_d;

   logic [3:0]    in_angle_s;
   logic [7:0]    in_dist_s;
   logic [7:0]    diff_s;
   logic [RW-1:0] rej_inc_s;
   logic          invalid_s;
   logic          new_angle_s;
   logic          outlier_s;
   logic          rej_below_s;

   // Classification of the latched sample, evaluated while in CHECK.
   always_comb begin
      in_angle_s  = in_q[11:8];
      in_dist_s   = in_q[7:0];
      if (in_dist_s >= last_q) begin
         diff_s = in_dist_s - last_q;
      end else begin
         diff_s = last_q - in_dist_s;
      end
      rej_inc_s   = rej_q + RW'(1);
      invalid_s   = (in_dist_s == 8'd0) || (in_angle_s > 4'd9);
      new_angle_s = (in_angle_s != angle_q) || (count_q == CW'(0));
      outlier_s   = (diff_s > 8'(MAX_JUMP));
      rej_below_s = (rej_inc_s < RW'(REJECT_LIMIT));
   end

   // Next-state and datapath decode.
   always_comb begin
      state_d    = state_q;
      in_d       = in_q;
      angle_d    = angle_q;
      last_d     = last_q;
      buf_d      = buf_q;
      wr_ptr_d   = wr_ptr_q;
      count_d    = count_q;
      rej_d      = rej_q;
      acc_idx_d  = acc_idx_q;
      sum_d      = sum_q;
      out_d      = out_q;
      fvalid_d   = 1'b0;
      rejected_d = 1'b0;
      overrun_d  = bus.location_valid && (state_q != IDLE);

      case (state_q)
         IDLE: begin
            if (bus.location_valid) begin
               in_d    = bus.rover_location;
               state_d = CHECK;
            end else begin
               state_d = IDLE;
            end
         end

         CHECK: begin
            state_d   = ACCUM;
            sum_d     = '0;
            acc_idx_d = '0;
            if (invalid_s) begin
               rejected_d = 1'b1;
               state_d    = IDLE;
            end else if (new_angle_s || (outlier_s && !rej_below_s)) begin
               // Restart the window: a new angle, or a persistent jump that is a real move.
               for (int i = 0; i < DEPTH; i++) begin
                  buf_d[i] = 8'd0;
               end
               buf_d[0] = in_dist_s;
               wr_ptr_d = DEPTH_LOG2'(1);
               count_d  = CW'(1);
               rej_d    = '0;
               angle_d  = in_angle_s;
               last_d   = in_dist_s;
            end else if (outlier_s) begin
               rej_d      = rej_inc_s;
               rejected_d = 1'b1;
               state_d    = IDLE;
            end else begin
               buf_d[wr_ptr_q] = in_dist_s;
               wr_ptr_d        = wr_ptr_q + DEPTH_LOG2'(1);
               if (count_q == CW'(DEPTH)) begin
                  count_d = count_q;
               end else begin
                  count_d = count_q + CW'(1);
               end
               rej_d  = '0;
               last_d = in_dist_s;
            end
         end

         ACCUM: begin
            sum_d     = sum_q + SW'(buf_q[acc_idx_q]);
            acc_idx_d = acc_idx_q + DEPTH_LOG2'(1);
            if (acc_idx_q == DEPTH_LOG2'(DEPTH - 1)) begin
               state_d = OUTPUT;
            end else begin
               state_d = ACCUM;
            end
         end

         OUTPUT: begin
            // Pass the newest sample through until the window has filled once.
            if (count_q == CW'(DEPTH)) begin
               out_d = {angle_q, sum_q[SW-1:DEPTH_LOG2]};
            end else begin
               out_d = {angle_q, last_q};
            end
            fvalid_d = 1'b1;
            state_d  = IDLE;
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and datapath registers.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q    <= IDLE;
         in_q       <= 12'd0;
         angle_q    <= 4'd0;
         last_q     <= 8'd0;
         for (int i = 0; i < DEPTH; i++) begin
            buf_q[i] <= 8'd0;
         end
         wr_ptr_q   <= '0;
         count_q    <= '0;
         rej_q      <= '0;
         acc_idx_q  <= '0;
         sum_q      <= '0;
         out_q      <= 12'd0;
         fvalid_q   <= 1'b0;
         rejected_q <= 1'b0;
         overrun_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         in_q       <= in_d;
         angle_q    <= angle_d;
         last_q     <= last_d;
         buf_q      <= buf_d;
         wr_ptr_q   <= wr_ptr_d;
         count_q    <= count_d;
         rej_q      <= rej_d;
         acc_idx_q  <= acc_idx_d;
         sum_q      <= sum_d;
         out_q      <= out_d;
         fvalid_q   <= fvalid_d;
         rejected_q <= rejected_d;
         overrun_q  <= overrun_d;
      end
   end

   assign bus.filtered_location = out_q;
   assign bus.filtered_valid    = fvalid_q;
   assign bus.rejected          = rejected_q;
   assign bus.overrun           = overrun_q;
   assign bus.sample_count      = count_q;
   assign bus.state             = state_q;

endmodule

// File: tb/tb_rover_location_filter.sv
// Scoreboard bench for rover_location_filter: a window model predicts each
// result when a sample is driven; a negedge monitor pops and compares.
module tb_rover_location_filter;

   logic clock;
   logic reset;
   int   n_total;
   int   n_bad;
   int   cyc;
   int   ovr_cnt;

   typedef struct {
      bit          is_rej;
      logic [11:0] loc;
      logic [2:0]  cnt;
      int          t_in;
   } exp_t;

   exp_t        sb_q[$];
   exp_t        mon_e;
   logic [11:0] last_out;
   logic [3:0]  m_angle;
   logic [7:0]  m_win[$];
   int          m_rej;

   rover_location_filter_if #(.DEPTH_LOG2(2)) bus ();

   rover_location_filter #(
      .DEPTH_LOG2  (2),
      .MAX_JUMP    (24),
      .REJECT_LIMIT(3)
   ) dut (
      .clock(clock),
      .reset(reset),
      .bus  (bus)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   always @(posedge clock) cyc++;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
      end
   endtask

   // Reference: keep the last (up to) four accepted distances as a sliding window.
   task automatic model_push(input logic [11:0] loc);
      logic [3:0] a;
      logic [7:0] d;
      exp_t       e;
      int         diff;
      int         sum;
      bit         accept;
      a        = loc[11:8];
      d        = loc[7:0];
      e.t_in   = cyc;
      e.is_rej = 1'b1;
      e.loc    = 12'd0;
      e.cnt    = 3'd0;
      accept   = 1'b0;
      if (d == 8'd0 || a > 4'd9) begin
         accept = 1'b0;
      end else if (m_win.size() == 0 || a != m_angle) begin
         m_win.delete();
         m_win.push_back(d);
         m_angle = a;
         m_rej   = 0;
         accept  = 1'b1;
      end else begin
         diff = int'(d) - int'(m_win[$]);
         if (diff < 0) diff = -diff;
         if (diff > 24) begin
            m_rej++;
            if (m_rej >= 3) begin
               m_win.delete();
               m_win.push_back(d);
               m_rej  = 0;
               accept = 1'b1;
            end
         end else begin
            m_win.push_back(d);
            if (m_win.size() > 4) void'(m_win.pop_front());
            m_rej  = 0;
            accept = 1'b1;
         end
      end
      if (accept) begin
         sum = 0;
         foreach (m_win[i]) sum += int'(m_win[i]);
         e.is_rej = 1'b0;
         e.cnt    = 3'(m_win.size());
         e.loc    = {a, (m_win.size() == 4) ? 8'(sum / 4) : m_win[$]};
      end
      sb_q.push_back(e);
   endtask

   task automatic send(input logic [11:0] loc, input bit predict);
      @(negedge clock);
      bus.rover_location = loc;
      bus.location_valid = 1'b1;
      if (predict) model_push(loc);
      @(negedge clock);
      bus.location_valid = 1'b0;
   endtask

   task automatic gap();
      repeat (20) @(negedge clock);
      check_val("pending", 32'(sb_q.size()), 32'd0);
      sb_q.delete();
   endtask

   task automatic check_reset_outputs(input string tag);
      check_val({tag, "_loc"},   32'(bus.filtered_location), 32'd0);
      check_val({tag, "_fval"},  32'(bus.filtered_valid),    32'd0);
      check_val({tag, "_rej"},   32'(bus.rejected),          32'd0);
      check_val({tag, "_ovr"},   32'(bus.overrun),           32'd0);
      check_val({tag, "_cnt"},   32'(bus.sample_count),      32'd0);
      check_val({tag, "_state"}, 32'(bus.state),             32'd0);
   endtask

   // Monitor: every result strobe is matched against the oldest prediction.
   always @(negedge clock) begin
      if (reset) begin
         if (bus.overrun) ovr_cnt++;
         if (bus.filtered_valid || bus.rejected) begin
            if (sb_q.size() == 0) begin
               check_val("unexpected_pulse", {30'd0, bus.filtered_valid, bus.rejected}, 32'd0);
            end else begin
               mon_e = sb_q.pop_front();
               check_val("kind", 32'(bus.rejected), 32'(mon_e.is_rej));
               check_val("latency", 32'(cyc - mon_e.t_in), mon_e.is_rej ? 32'd2 : 32'd7);
               if (!mon_e.is_rej) begin
                  check_val("location", 32'(bus.filtered_location), 32'(mon_e.loc));
                  check_val("count", 32'(bus.sample_count), 32'(mon_e.cnt));
                  last_out = mon_e.loc;
               end else begin
                  check_val("held_location", 32'(bus.filtered_location), 32'(last_out));
               end
            end
         end
      end
   end

   initial begin
      n_total = 0;
      n_bad   = 0;
      cyc     = 0;
      ovr_cnt = 0;
      last_out = 12'd0;
      m_angle = 4'd0;
      m_rej   = 0;
      reset   = 1'b0;
      bus.location_valid = 1'b0;
      bus.rover_location = 12'd0;

      repeat (3) @(negedge clock);
      check_reset_outputs("por");
      reset = 1'b1;
      repeat (2) @(negedge clock);

      // Reset landing in the middle of ACCUM discards the pending result.
      send(12'h3C8, 1'b0);
      repeat (2) @(negedge clock);
      check_val("pre_reset_state", 32'(bus.state), 32'd2);
      reset = 1'b0;
      #1;
      check_reset_outputs("mid");
      m_win.delete();
      m_rej    = 0;
      m_angle  = 4'd0;
      last_out = 12'd0;
      repeat (2) @(negedge clock);
      reset = 1'b1;
      gap();

      // Ramp: passthrough until full, then mean of 40,42,44,46 = 43.
      send(12'h328, 1'b1); gap();
      send(12'h32A, 1'b1); gap();
      send(12'h32C, 1'b1); gap();
      send(12'h32E, 1'b1); gap();
      check_val("ramp_mean", 32'(bus.filtered_location), 32'h32B);

      // Angle change, then two invalid inputs.
      send(12'h53C, 1'b1); gap();
      check_val("angle_cnt", 32'(bus.sample_count), 32'd1);
      send(12'h500, 1'b1); gap();
      send(12'hA3C, 1'b1); gap();
      check_val("invalid_hold", 32'(bus.filtered_location), 32'h53C);

      // Refill at angle 3, then a persistent jump to 100.
      send(12'h328, 1'b1); gap();
      send(12'h32A, 1'b1); gap();
      send(12'h32C, 1'b1); gap();
      send(12'h32E, 1'b1); gap();
      send(12'h364, 1'b1); gap();
      send(12'h364, 1'b1); gap();
      check_val("outlier_hold", 32'(bus.filtered_location), 32'h32B);
      send(12'h364, 1'b1); gap();
      check_val("outlier_accept", 32'(bus.filtered_location), 32'h364);
      check_val("outlier_cnt", 32'(bus.sample_count), 32'd1);

      // Second strobe two cycles after the first is dropped.
      ovr_cnt = 0;
      @(negedge clock);
      bus.rover_location = 12'h370;
      bus.location_valid = 1'b1;
      model_push(12'h370);
      @(negedge clock);
      bus.location_valid = 1'b0;
      @(negedge clock);
      bus.rover_location = 12'h310;
      bus.location_valid = 1'b1;
      @(negedge clock);
      bus.location_valid = 1'b0;
      gap();
      check_val("overrun_pulses", 32'(ovr_cnt), 32'd1);
      check_val("overrun_first", 32'(bus.filtered_location), 32'h370);

      // Wrap-around: final window is 54,56,58,60.
      for (int i = 0; i < 6; i++) begin
         send({4'h6, 8'(50 + 2 * i)}, 1'b1);
         gap();
      end
      check_val("wrap_final", 32'(bus.filtered_location), 32'h639);
      check_val("wrap_cnt", 32'(bus.sample_count), 32'd4);
      check_val("no_stray_overrun", 32'(ovr_cnt), 32'd1);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule

// File: doc/rover_location_filter.md
# rover_location_filter

Smoothing stage directly downstream of `ultrasound_location_calculator`. Consumes each `{angle_index, distance}` result and its one-cycle `done` strobe. Rejects single-shot echo outliers and keeps a ring buffer of accepted distances for the current angle. Emits a running mean to the rover path/display logic with a one-cycle valid strobe.

## Interface
- `DEPTH_LOG2`, 2: log2 of ring buffer depth; DEPTH = 2^DEPTH_LOG2 (4).
- `MAX_JUMP`, 24: largest accepted |distance − last accepted distance|, in distance LSBs.
- `REJECT_LIMIT`, 3: consecutive outliers after which the outlier is accepted as a real move.
- `clock`  in  1: system clock; all state updates on the rising edge.
- `reset`  in  1: asynchronous, active-low reset.
- `location_valid`  in  1: one-cycle strobe, driven by calculator `done`.
- `rover_location`  in  12: `[11:8]` angle_index (0–9 legal), `[7:0]` distance.
- `filtered_location`  out  12: `{angle_index, mean distance}`; holds its value between updates.
- `filtered_valid`  out  1: one-cycle strobe when `filtered_location` updates.
- `rejected`  out  1: one-cycle strobe when an input is discarded.
- `overrun`  out  1: one-cycle strobe when `location_valid` arrives while busy.
- `sample_count`  out  DEPTH_LOG2+1: accepted samples in the buffer, saturating at DEPTH.
- `state`  out  3: FSM state, for debug. Encoding: IDLE=0, CHECK=1, ACCUM=2, OUTPUT=3.

## Operation
- **Reset (reset low):** all outputs 0, buffer and counters cleared, `state` = IDLE. Reset takes effect immediately, including mid-ACCUM. A pending result is lost.
- **IDLE:** on `location_valid`, latch `rover_location` and go to CHECK. Other inputs are ignored.
- **CHECK** (one cycle):
  - **Invalid input.** Condition: distance == 0 (no echo) or angle_index > 9. Action: pulse `rejected`, change no other state, return to IDLE.
  - **New angle.** Condition: angle_index differs from the stored angle, or the buffer is empty. Action: flush the buffer, store the angle, write the sample, set count = 1, clear the reject counter.
  - **Outlier.** Condition: |distance − last accepted| > MAX_JUMP.
    - Increment the reject counter.
    - If the counter is now below REJECT_LIMIT: pulse `rejected`, return to IDLE.
    - Otherwise: flush the buffer, write the sample, set count = 1, clear the counter.
  - **Otherwise:** write the sample at the write pointer, advance the pointer (wraps modulo DEPTH), saturate count at DEPTH, clear the reject counter.
- **ACCUM:** add one buffer entry per cycle, exactly DEPTH cycles regardless of count, into a sum of width 8+DEPTH_LOG2. No overflow is possible.
- **OUTPUT:**
  - If count == DEPTH: mean = sum >> DEPTH_LOG2 (truncating).
  - Otherwise: mean = newest sample (passthrough until the buffer first fills).
  - Register `filtered_location` = {stored angle, mean}, pulse `filtered_valid`, return to IDLE.
- **Overrun:** `location_valid` seen in CHECK, ACCUM or OUTPUT is dropped and `overrun` is pulsed the next cycle. A valid in the same cycle as the return to IDLE is also dropped. A new sample is accepted only while `state` == IDLE.

## Timing
- Let `location_valid` be sampled at edge N.
- CHECK occupies the cycle after edge N.
- ACCUM spans edges N+2 … N+DEPTH+1.
- `filtered_valid` is high for the single cycle following edge N+DEPTH+2 (6 cycles for DEPTH = 4).
- `rejected` is high for the single cycle following edge N+1.
- Minimum spacing between accepted inputs is DEPTH+3 cycles. The calculator's measurement period is far longer.
- `sample_count` updates at the end of CHECK. `filtered_location` changes only with `filtered_valid`.

## Test plan
- **Reset:** hold `reset` low mid-stream, then release. Require all outputs 0 and `state` 0. After release, input 0x328 gives `filtered_location` 0x328 with `sample_count` 1.
- **Ramp:** angle 3, distances 40, 42, 44, 46, spaced 20 cycles apart. Require outputs 0x328, 0x32A, 0x32C, then 0x32B (mean 43). Each `filtered_valid` must come 6 cycles after its input.
- **Outlier:**
  - Start from a full buffer at 46.
  - Input 0x364 (distance 100): `rejected` pulses, no `filtered_valid`.
  - A second 0x364: also `rejected`.
  - A third 0x364: accepted with `filtered_location` 0x364 and `sample_count` 1.
- **Angle change:** after the ramp, input 0x53C. Require `sample_count` 1 and output 0x53C. An input with distance 0, or angle 0xA, gives `rejected` and leaves `filtered_location` unchanged.
- **Overrun:** two `location_valid` strobes 2 cycles apart. Require `overrun` to pulse once and exactly one `filtered_valid`, carrying the first sample.
- **Wrap-around:** feed 6 in-range samples 50, 52, 54, 56, 58, 60. Require the final output {angle, 57}, the mean of the last four.
